// File: rtl/posit_quire_stream_accumulator.sv
// rtl/posit_quire_stream_accumulator.sv - exact quire summation of a posit stream with RNE result
//
// Purpose: accumulates a valid/ready stream of packed posits exactly in a
// Kulisch quire. It emits one rounded posit (round-to-nearest-even on the
// encoding) plus the element count per stream. A stream ends with inLast.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   inValid/inReady      element handshake
//   inData [WIDTH]       packed posit element
//   inNegate             subtract the element instead of adding it
//   inLast               element closes the current stream
//   outValid/outReady    result handshake
//   outData [WIDTH]      rounded posit sum (NaR if any element was NaR)
//   outCount [COUNT_BITS] elements in the stream, saturating
//   outOverflow          only with POSIT_QUIRE_ACC_OVERFLOW_FLAG_EN: quire wrapped
//
// Optional feature macro: POSIT_QUIRE_ACC_OVERFLOW_FLAG_EN
// Assumes ES >= 1 and WIDTH >= ES + 4.
module posit_quire_stream_accumulator #(
  parameter int WIDTH      = 8,
  parameter int ES         = 1,
  parameter int OVERFLOW   = 0,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [WIDTH-1:0]      inData,
  input  logic                  inNegate,
  input  logic                  inLast,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [WIDTH-1:0]      outData,
  output logic [COUNT_BITS-1:0] outCount
`ifdef POSIT_QUIRE_ACC_OVERFLOW_FLAG_EN
  ,
  output logic                  outOverflow
`endif
);

  localparam int MAX_SCALE = (WIDTH - 2) << ES;
  localparam int FW        = WIDTH - 3 - ES;   // widest fraction field of any posit

  function automatic int get_frac_bits();
    return MAX_SCALE;                          // lsb weight 2^-MAX_SCALE = minpos
  endfunction

  function automatic int get_non_frac_bits(input int ovf);
    return MAX_SCALE + 2 + ovf;                // sign + integer bits reaching maxpos + guard
  endfunction

  localparam int FRAC_BITS    = get_frac_bits();
  localparam int NONFRAC_BITS = get_non_frac_bits(OVERFLOW);
  localparam int QW           = NONFRAC_BITS + FRAC_BITS;
  localparam int SW           = $clog2(MAX_SCALE + 1) + 2;
  localparam int EW           = QW + FW + 1;
  localparam int LW           = ES + QW + WIDTH;
  localparam logic [WIDTH-1:0] NAR = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 inf;
    logic signed [SW-1:0] scale;
    logic [FW-1:0]        frac;
  } elem_t;

  typedef enum logic [1:0] {ACCUM, ROUND, HOLD} state_t;

  // Posit decode to sign / scale / fraction. Regime run length sets the
  // coarse scale; exponent bits cut off by a long regime read as zero.
  function automatic elem_t decode(input logic [WIDTH-1:0] p, input logic neg);
    elem_t            d;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] rest;
    int               run;
    int               k;
    int               e;
    logic             stop;
    d = '0;
    if (p == '0) begin
      d.zero = 1'b1;
    end else if (p == NAR) begin
      d.inf = 1'b1;
    end else begin
      a    = p[WIDTH-1] ? -p : p;
      run  = 0;
      stop = 1'b0;
      for (int i = WIDTH - 2; i >= 0; i--) begin
        if (!stop && (a[i] == a[WIDTH-2])) run++;
        else stop = 1'b1;
      end
      k       = a[WIDTH-2] ? run - 1 : -run;
      rest    = {a[WIDTH-2:0], 1'b0} << (run + 1);
      e       = int'(rest[WIDTH-1 -: ES]);
      d.scale = SW'(k * (1 << ES) + e);
      d.frac  = rest[WIDTH-1-ES -: FW];
      d.sign  = p[WIDTH-1] ^ neg;
    end
    return d;
  endfunction

  // Exact fixed-point image of an element, two's complement modulo 2^QW.
  function automatic logic [QW-1:0] to_quire(input elem_t d);
    logic [EW-1:0] m;
    logic [QW-1:0] q;
    int            sh;
    if (d.zero || d.inf) return '0;
    m  = EW'({1'b1, d.frac});
    sh = int'(d.scale) + FRAC_BITS - FW;
    m  = (sh >= 0) ? (m << sh) : (m >> (-sh));
    q  = m[QW-1:0];
    return d.sign ? -q : q;
  endfunction

  // Quire to posit: build the unbounded encoding (regime, exponent, all
  // remaining quire bits) left-aligned, then round the encoding with
  // guard, round and sticky bits. Magnitudes outside [minpos, maxpos]
  // clamp, so a nonzero sum never becomes zero.
  function automatic logic [WIDTH-1:0] quire_to_posit(input logic [QW-1:0] q);
    logic            s;
    logic [QW-1:0]   mag;
    logic [QW-1:0]   frac;
    logic [LW-1:0]   regime;
    logic [LW-1:0]   body;
    logic [LW-1:0]   v;
    logic [WIDTH-2:0] pat;
    logic            guard;
    logic            rnd;
    logic            sticky;
    int              p;
    int              scale;
    int              k;
    int              e;
    int              rlen;
    s   = q[QW-1];
    mag = s ? -q : q;
    if (mag == '0) return '0;
    p = 0;
    for (int i = 0; i < QW; i++) begin
      if (mag[i]) p = i;
    end
    scale = p - FRAC_BITS;
    if (scale > MAX_SCALE) begin
      pat = '1;
    end else if (scale < -MAX_SCALE) begin
      pat = (WIDTH-1)'(1);
    end else begin
      k    = scale >>> ES;
      e    = scale - (k << ES);
      frac = mag << (QW - p);                  // drops the hidden one
      body = {ES'(e), frac, {WIDTH{1'b0}}};
      if (k >= 0) begin
        regime = ~({LW{1'b1}} >> (k + 1));
        rlen   = k + 2;
      end else begin
        regime = {1'b1, {(LW-1){1'b0}}} >> (-k);
        rlen   = 1 - k;
      end
      v      = regime | (body >> rlen);
      pat    = v[LW-1 -: WIDTH-1];
      guard  = v[LW-WIDTH];
      rnd    = v[LW-WIDTH-1];
      sticky = |v[LW-WIDTH-2:0];
      if (guard && (rnd || sticky || pat[0])) pat = pat + 1'b1;
    end
    return s ? -{1'b0, pat} : {1'b0, pat};
  endfunction

  state_t                state;
  state_t                next_state;
  logic                  s1_valid;
  logic                  s1_last;
  elem_t                 s1_elem;
  logic [QW-1:0]         quire;
  logic [QW-1:0]         elem_q;
  logic [QW-1:0]         quire_sum;
  logic                  inf_flag;
  logic [COUNT_BITS-1:0] counter;
  logic                  accept;

  assign accept    = inValid && inReady;
  assign elem_q    = to_quire(s1_elem);
  assign quire_sum = quire + elem_q;

  always_ff @(posedge clock) begin
    if (reset) state <= ACCUM;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    inReady    = 1'b0;
    case (state)
      ACCUM: begin
        // Block new elements while the stream's last one is in flight.
        inReady = !(s1_valid && s1_last);
        if (s1_valid && s1_last) next_state = ROUND;
      end
      ROUND: next_state = HOLD;
      HOLD:  if (outReady) next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_elem  <= '0;
      quire    <= '0;
      inf_flag <= 1'b0;
      counter  <= '0;
      outValid <= 1'b0;
      outData  <= '0;
      outCount <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_elem <= decode(inData, inNegate);
        s1_last <= inLast;
      end
      case (state)
        ACCUM: begin
          if (s1_valid) begin
            quire    <= quire_sum;
            inf_flag <= inf_flag | s1_elem.inf;
            if (counter != '1) counter <= counter + 1'b1;
          end
        end
        ROUND: begin
          outData  <= inf_flag ? NAR : quire_to_posit(quire);
          outCount <= counter;
          outValid <= 1'b1;
        end
        HOLD: begin
          if (outReady) begin
            outValid <= 1'b0;
            quire    <= '0;
            inf_flag <= 1'b0;
            counter  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef POSIT_QUIRE_ACC_OVERFLOW_FLAG_EN
  logic ovf_sticky;
  logic add_ovf;

  assign add_ovf = (quire[QW-1] == elem_q[QW-1]) && (quire_sum[QW-1] != quire[QW-1]);

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_sticky  <= 1'b0;
      outOverflow <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (s1_valid && add_ovf) ovf_sticky <= 1'b1;
        ROUND: outOverflow <= ovf_sticky;
        HOLD:  if (outReady) ovf_sticky <= 1'b0;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_posit_quire_stream_accumulator.sv
// tb/tb_posit_quire_stream_accumulator.sv - self-checking bench for posit_quire_stream_accumulator
module tb_posit_quire_stream_accumulator;

`ifdef POSIT_QUIRE_ACC_OVERFLOW_FLAG_EN
  localparam int OVF = -1;
`else
  localparam int OVF = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [7:0]  inData = 8'h00;
  logic        inNegate = 1'b0;
  logic        inLast = 1'b0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [7:0]  outData;
  logic [15:0] outCount;
`ifdef POSIT_QUIRE_ACC_OVERFLOW_FLAG_EN
  logic        outOverflow;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  posit_quire_stream_accumulator #(
    .WIDTH(8), .ES(1), .OVERFLOW(OVF), .COUNT_BITS(16)
  ) dut (
    .clock(clock), .reset(reset),
    .inValid(inValid), .inReady(inReady), .inData(inData),
    .inNegate(inNegate), .inLast(inLast),
    .outValid(outValid), .outReady(outReady),
    .outData(outData), .outCount(outCount)
`ifdef POSIT_QUIRE_ACC_OVERFLOW_FLAG_EN
    , .outOverflow(outOverflow)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model (real arithmetic, ES=1) ----------------
  function automatic real pow2(input int x);
    real r;
    r = 1.0;
    if (x >= 0) for (int i = 0; i < x; i++) r = r * 2.0;
    else        for (int i = 0; i < -x; i++) r = r / 2.0;
    return r;
  endfunction

  // Value of an n-bit posit pattern (n up to 9), not NaR.
  function automatic real pos_val(input int bits, input int n);
    int  mask, b, a, sgn, first, run, i, k, e;
    real f, w, v;
    mask = (1 << n) - 1;
    b    = bits & mask;
    if (b == 0) return 0.0;
    sgn   = (b >> (n - 1)) & 1;
    a     = (sgn != 0) ? ((mask + 1 - b) & mask) : b;
    first = (a >> (n - 2)) & 1;
    run   = 0;
    i     = n - 2;
    while (i >= 0 && (((a >> i) & 1) == first)) begin run++; i--; end
    k = (first != 0) ? run - 1 : -run;
    i--;
    e = 0;
    if (i >= 0) begin e = (a >> i) & 1; i--; end
    f = 1.0;
    w = 0.5;
    while (i >= 0) begin
      if (((a >> i) & 1) != 0) f = f + w;
      w = w / 2.0;
      i--;
    end
    v = f * pow2(2 * k + e);
    return (sgn != 0) ? -v : v;
  endfunction

  // Round to 8-bit posit: midpoints are the 9-bit posits between neighbours,
  // ties go to the even pattern, magnitudes clamp to [minpos, maxpos].
  function automatic logic [7:0] model_round(input real x);
    real        ax, m;
    int         p;
    logic [7:0] r;
    if (x == 0.0) return 8'h00;
    ax = (x < 0.0) ? -x : x;
    if (ax >= pos_val(127, 8)) p = 127;
    else if (ax <= pos_val(1, 8)) p = 1;
    else begin
      p = 1;
      while (pos_val(p + 1, 8) <= ax) p++;
      if (ax != pos_val(p, 8)) begin
        m = pos_val(2 * p + 1, 9);
        if (ax > m) p++;
        else if (ax == m && (p % 2) == 1) p++;
      end
    end
    r = 8'(p);
    return (x < 0.0) ? -r : r;
  endfunction

  // ---------------- transport ----------------
  task automatic push(input logic [7:0] d, input logic neg, input logic last);
    int n;
    n = 0;
    inValid = 1'b1; inData = d; inNegate = neg; inLast = last;
    while (!inReady && n < 50) begin @(negedge clock); n++; end
    checks++;
    if (inReady !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout: inReady=%0b required 1 within 50 cycles", inReady);
    end
    @(negedge clock);
    inValid = 1'b0; inLast = 1'b0; inNegate = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (outValid !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    checks++;
    if (outValid !== 1'b1) begin
      errors++;
      $display("FAIL result_timeout: outValid=%0b required 1 within 50 cycles", outValid);
    end
  endtask

  task automatic handshake();
    outReady = 1'b1;
    @(negedge clock);
    outReady = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %0b want 0", outValid); end
    checks++; if (outData !== 8'h00) begin errors++; $display("FAIL reset_outData: got %h want 00", outData); end
    checks++; if (outCount !== 16'd0) begin errors++; $display("FAIL reset_outCount: got %0d want 0", outCount); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady: got %0b want 1", inReady); end
`ifdef POSIT_QUIRE_ACC_OVERFLOW_FLAG_EN
    checks++; if (outOverflow !== 1'b0) begin errors++; $display("FAIL reset_outOverflow: got %0b want 0", outOverflow); end
`endif
  endtask

  task automatic test_single();
    int lat;
    push(8'h40, 1'b0, 1'b1);
    lat = 1;
    while (outValid !== 1'b1 && lat < 20) begin @(negedge clock); lat++; end
    checks++; if (lat != 3) begin errors++; $display("FAIL single_latency: got %0d cycles want 3", lat); end
    checks++; if (outData !== 8'h40) begin errors++; $display("FAIL single_data: got %h want 40", outData); end
    checks++; if (outCount !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", outCount); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    for (int i = 0; i < 4; i++) push(8'h40, 1'b0, (i == 3));
    checks++; if (cyc != c0 + 4) begin errors++; $display("FAIL b2b_cycles: got %0d want 4", cyc - c0); end
    for (int i = 1; i <= 3; i++) begin
      checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL b2b_inReady_low c%0d: got %0b want 0", i, inReady); end
      if (i < 3) @(negedge clock);
    end
    checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b want 1", outValid); end
    checks++; if (outData !== 8'h60) begin errors++; $display("FAIL b2b_data: got %h want 60", outData); end
    checks++; if (outCount !== 16'd4) begin errors++; $display("FAIL b2b_count: got %0d want 4", outCount); end
    handshake();
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL b2b_inReady_back: got %0b want 1", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %0b want 0", outValid); end
  endtask

  task automatic test_sums();
    push(8'h40, 1'b0, 1'b0);
    push(8'h30, 1'b0, 1'b1);
    wait_valid();
    checks++; if (outData !== 8'h48) begin errors++; $display("FAIL sum_1p5: got %h want 48", outData); end
    handshake();
    push(8'h40, 1'b0, 1'b0);
    push(8'h40, 1'b1, 1'b1);
    wait_valid();
    checks++; if (outData !== 8'h00) begin errors++; $display("FAIL sum_zero: got %h want 00", outData); end
    checks++; if (outCount !== 16'd2) begin errors++; $display("FAIL sum_zero_count: got %0d want 2", outCount); end
    handshake();
  endtask

  task automatic test_nar();
    push(8'h40, 1'b0, 1'b0);
    push(8'h80, 1'b1, 1'b0);
    push(8'h40, 1'b0, 1'b1);
    wait_valid();
    checks++; if (outData !== 8'h80) begin errors++; $display("FAIL nar_data: got %h want 80", outData); end
    checks++; if (outCount !== 16'd3) begin errors++; $display("FAIL nar_count: got %0d want 3", outCount); end
    handshake();
    push(8'h40, 1'b0, 1'b1);
    wait_valid();
    checks++; if (outData !== 8'h40) begin errors++; $display("FAIL nar_cleared: got %h want 40", outData); end
    handshake();
  endtask

  task automatic test_backpressure();
    push(8'h40, 1'b0, 1'b0);
    push(8'h30, 1'b0, 1'b1);
    wait_valid();
    inValid = 1'b1; inData = 8'h40; inLast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (outValid !== 1'b1 || outData !== 8'h48 || outCount !== 16'd2 || inReady !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold c%0d: valid=%0b data=%h count=%0d ready=%0b want 1 48 2 0",
                 i, outValid, outData, outCount, inReady);
      end
    end
    inValid = 1'b0; inLast = 1'b0;
    handshake();
    push(8'h40, 1'b0, 1'b1);
    wait_valid();
    checks++; if (outCount !== 16'd1) begin errors++; $display("FAIL bp_ignored_count: got %0d want 1", outCount); end
    handshake();
    push(8'h40, 1'b0, 1'b0);
    push(8'h40, 1'b0, 1'b1);
    wait_valid();
    reset = 1'b1;
    @(negedge clock);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL hold_reset_valid: got %0b want 0", outValid); end
    reset = 1'b0;
    push(8'h30, 1'b0, 1'b1);
    wait_valid();
    checks++; if (outData !== 8'h30 || outCount !== 16'd1) begin
      errors++; $display("FAIL after_reset: data=%h count=%0d want 30 1", outData, outCount);
    end
    handshake();
  endtask

  task automatic test_random();
    for (int s = 0; s < 30; s++) begin
      int         len;
      logic [7:0] pat;
      logic       neg;
      logic       nar;
      real        sum, v;
      logic [7:0] exp_d;
      len = $urandom_range(1, 6);
      sum = 0.0;
      nar = 1'b0;
      for (int i = 0; i < len; i++) begin
        do begin
          pat = 8'($urandom_range(0, 255));
          v   = (pat == 8'h80) ? 0.0 : pos_val(int'(pat), 8);
        end while (pat == 8'h80 || v > 256.0 || v < -256.0);
        if ($urandom_range(0, 19) == 0) pat = 8'h80;
        neg = 1'($urandom_range(0, 1));
        if (pat == 8'h80) nar = 1'b1;
        else sum = sum + (neg ? -v : v);
        repeat ($urandom_range(0, 2)) @(negedge clock);
        push(pat, neg, (i == len - 1));
      end
      exp_d = nar ? 8'h80 : model_round(sum);
      wait_valid();
      repeat ($urandom_range(0, 3)) @(negedge clock);
      checks++;
      if (outData !== exp_d || outCount !== 16'(len)) begin
        errors++;
        $display("FAIL random s%0d: data=%h count=%0d want %h %0d", s, outData, outCount, exp_d, len);
      end
      handshake();
    end
  endtask

`ifdef POSIT_QUIRE_ACC_OVERFLOW_FLAG_EN
  task automatic test_overflow();
    for (int i = 0; i < 3; i++) push(8'h7F, 1'b0, (i == 2));
    wait_valid();
    checks++; if (outOverflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b want 1", outOverflow); end
    handshake();
    push(8'h40, 1'b0, 1'b1);
    wait_valid();
    checks++; if (outOverflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b want 0", outOverflow); end
    checks++; if (outData !== 8'h40) begin errors++; $display("FAIL ovf_next_data: got %h want 40", outData); end
    handshake();
  endtask
`endif

  initial begin
    @(negedge clock);
    test_reset();
    test_single();
    test_back_to_back();
    test_sums();
    test_nar();
    test_backpressure();
    test_random();
`ifdef POSIT_QUIRE_ACC_OVERFLOW_FLAG_EN
    test_overflow();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/posit_quire_stream_accumulator.md
Name: posit_quire_stream_accumulator

Overview:
- Sequential reduction stage that sums a stream of packed posits exactly in a Kulisch quire.
- Emits one rounded packed posit per stream, using round-to-nearest-even.
- Sits downstream of posit producers (decode/multiply lanes) and upstream of posit writeback.
- Wraps per-element posit-to-quire conversion, quire accumulation, and quire-to-posit rounding in a valid/ready pipelined FSM.

Parameters:
- WIDTH, 8, packed posit width in bits.
- ES, 1, posit exponent field size.
- OVERFLOW, 0, extra quire integer guard bits, passed to QuireDef::getNonFracBits / getFracBits. May be negative.
- COUNT_BITS, 16, width of the element counter reported with each result.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- inValid  input  1  input element valid
- inReady  output  1  block can accept an element this cycle
- inData  input  WIDTH  packed posit element
- inNegate  input  1  element is subtracted instead of added
- inLast  input  1  element is the final one of the current stream
- outValid  output  1  result valid
- outReady  input  1  consumer accepts result
- outData  output  WIDTH  rounded packed posit sum
- outCount  output  COUNT_BITS  number of elements in the stream; saturates at all-ones

Behaviour:
- Reset: all of the following are cleared.
  - Outputs: outValid=0, outData=0, outCount=0, inReady=1 from the first cycle after reset.
  - Internal state: quire=zero(), infFlag=0, counter=0, stage-1 valid=0, state=ACCUM.
  - Reset asserted mid-stream or during HOLD discards all partial state and any pending result; no output is produced for the aborted stream.
- Handshake: an element is accepted in a cycle with inValid&&inReady. The result is consumed in a cycle with outValid&&outReady.
- Stage 1 (registered on accept):
  - Decode inData.
  - Convert to fixed exp/frac/sign/inf.
  - Sign is XORed with inNegate. Negating zero or NaR has no effect.
  - Register exp, frac, sign, inf, last, valid.
- Stage 2: when stage-1 is valid, quire <= quire + converted element (exact, two's complement).
  - infFlag <= infFlag | inf.
  - counter <= counter + 1, saturating.
- FSM states and transitions:
  - ACCUM: inReady = !(s1Valid && s1Last). When the stage-2 update consumes a last element, go to ROUND.
  - ROUND: inReady=0. Quire-to-posit conversion (2 trailing bits + sticky) feeds RNE, and the result is registered into outData.
    - If infFlag is set, outData=NaR (1 followed by WIDTH-1 zeros).
    - outCount <= counter. outValid <= 1. Go to HOLD.
  - HOLD: inReady=0. outValid, outData and outCount stay stable until outReady.
    - On the output handshake: outValid <= 0; quire, infFlag and counter clear; go to ACCUM.
    - inReady returns to 1 in the cycle after the handshake.
- Latency: if the last element is accepted in cycle 0, outValid=1 in cycle 3.
- Throughput: one element per cycle within a stream. Inter-stream gap is at least 1 cycle after the output handshake.
- Zero result: an exact sum of 0 produces outData=0. Zero is never rounded to minpos.
- Quire arithmetic wraps modulo the quire width. No saturation is applied.

Optional Feature:
- Macro: POSIT_QUIRE_ACC_OVERFLOW_FLAG_EN.
- When defined:
  - Adds output port outOverflow (1 bit). Its reset value is 0.
  - An internal sticky bit sets when any stage-2 addition has signed overflow of the quire (operand signs equal, result sign differs).
  - The sticky bit is copied to outOverflow in ROUND, held through HOLD, and cleared with the quire.
  - outData is unaffected by the flag.
- When undefined: no port and no overflow logic. Wrap behaviour is unchanged.

Test Plan:
All values use WIDTH=8, ES=1.
- Single element: 0x40 (1.0) with inLast → outData=0x40, outCount=1, outValid exactly 3 cycles after the accept.
- Four-element stream of 0x40, back-to-back, last on the 4th → outData=0x60 (4.0), outCount=4. inReady low from the cycle after the last accept until the cycle after the output handshake.
- Stream 0x40, 0x30 (0.5) → 0x48 (1.5). Stream 0x40, 0x40 with inNegate on the 2nd → 0x00, outCount=2.
- Stream 0x40, 0x80 (NaR), 0x40 → outData=0x80, outCount=3. The next stream 0x40 alone → 0x40, showing infFlag was cleared.
- Backpressure: hold outReady=0 for 5 cycles after outValid → outData, outCount and outValid stay stable and inValid is ignored. Assert reset while in HOLD → outValid=0 next cycle, and the next stream result is correct.
- With POSIT_QUIRE_ACC_OVERFLOW_FLAG_EN and OVERFLOW=-1: repeated 0x7F (maxpos) until wrap → outOverflow=1. A following short stream → outOverflow=0.
